matrix_stream_loader: RTL and testbench

//   Upstream feeder for the combinational parallel multiplier. Accepts a size config, then

---
 rtl/matrix_pkg.sv | 21 ++
 rtl/matrix_rc_counter.sv | 67 ++++++
 rtl/matrix_stream_loader.sv | 145 ++++++++++++++
 tb/tb_matrix_stream_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix stream loader.
// Optional build macro used by the loader: LOADER_B_COLMAJOR_EN (B streamed column-major).
package matrix_pkg;

  localparam int MAX_SIZE_DEF   = 10;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int IDX_W          = (MAX_SIZE_DEF > 1) ? $clog2(MAX_SIZE_DEF) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Flat element index of (r,c) in a row-major bus with the given row stride.
  function automatic int idx(input int r, input int c, input int stride = MAX_SIZE_DEF);
    return (r * stride) + c;
  endfunction

endpackage

// File: rtl/matrix_rc_counter.sv
// Row/column walker over an N x N grid; row-major or column-major order.
// The flag 'last' marks the final position of the walk (N-1, N-1).
module matrix_rc_counter
  import matrix_pkg::*;
#(
  parameter int RC_W = IDX_W,
  parameter int N_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            step,
  input  logic [N_W-1:0]  n,
  input  logic            col_major,
  output logic [RC_W-1:0] row,
  output logic [RC_W-1:0] col,
  output logic            last
);

  logic [RC_W-1:0] row_r;
  logic [RC_W-1:0] col_r;
  logic [N_W-1:0]  n_m1_s;
  logic            row_end_s;
  logic            col_end_s;

  // End-of-row / end-of-column detection against N-1.
  always_comb begin
    n_m1_s    = n - N_W'(1);
    row_end_s = (N_W'(row_r) == n_m1_s);
    col_end_s = (N_W'(col_r) == n_m1_s);
  end

  // Advance the walk position on each step; wrap to (0,0) after the last element.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_r <= {RC_W{1'b0}};
      col_r <= {RC_W{1'b0}};
    end else if (clear) begin
      row_r <= {RC_W{1'b0}};
      col_r <= {RC_W{1'b0}};
    end else if (step) begin
      if (col_major) begin
        if (row_end_s) begin
          row_r <= {RC_W{1'b0}};
          col_r <= col_end_s ? {RC_W{1'b0}} : (col_r + RC_W'(1));
        end else begin
          row_r <= row_r + RC_W'(1);
        end
      end else begin
        if (col_end_s) begin
          col_r <= {RC_W{1'b0}};
          row_r <= row_end_s ? {RC_W{1'b0}} : (row_r + RC_W'(1));
        end else begin
          col_r <= col_r + RC_W'(1);
        end
      end
    end else begin
      row_r <= row_r;
      col_r <= col_r;
    end
  end

  assign row  = row_r;
  assign col  = col_r;
  assign last = row_end_s && col_end_s;

endmodule

// File: rtl/matrix_stream_loader.sv
// Streams A then B element-by-element into flat row-major buses for the parallel
// multiplier and holds them with mats_valid until the consumer takes them.
// Build macro LOADER_B_COLMAJOR_EN: B arrives column-major (stored layout unchanged).
module matrix_stream_loader
  import matrix_pkg::*;
#(
  parameter int MAX_SIZE   = MAX_SIZE_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_valid,
  input  logic [31:0]                            cfg_size,
  output logic                                   cfg_ready,
  output logic                                   cfg_err,
  input  logic                                   in_valid,
  input  logic [DATA_WIDTH-1:0]                  in_data,
  output logic                                   in_ready,
  output logic [31:0]                            matrix_size,
  output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] A,
  output logic [MAX_SIZE*MAX_SIZE*DATA_WIDTH-1:0] B,
  output logic                                   mats_valid,
  input  logic                                   mats_ready
);

  localparam int RC_W  = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
  localparam int N_W   = $clog2(MAX_SIZE + 1);
  localparam int FLAT_W = MAX_SIZE * MAX_SIZE * DATA_WIDTH;

  state_t                  state_r;
  logic [FLAT_W-1:0]       a_r;
  logic [FLAT_W-1:0]       b_r;
  logic [31:0]             matrix_size_r;
  logic                    mats_valid_r;
  logic                    cfg_err_r;

  logic                    cfg_ready_s;
  logic                    in_ready_s;
  logic                    cfg_legal_s;
  logic                    cfg_accept_s;
  logic                    elem_accept_s;
  logic                    col_major_s;
  logic [RC_W-1:0]         row_s;
  logic [RC_W-1:0]         col_s;
  logic                    last_s;
  int                      wr_base_s;

  // Handshake readiness and config legality decoded from the current state.
  always_comb begin
    cfg_ready_s   = (state_r == IDLE);
    in_ready_s    = (state_r == LOAD_A) || (state_r == LOAD_B);
    cfg_legal_s   = (cfg_size != 32'd0) && (cfg_size <= 32'(MAX_SIZE));
    cfg_accept_s  = cfg_valid && cfg_ready_s && cfg_legal_s;
    elem_accept_s = in_valid && in_ready_s;
    wr_base_s     = idx(int'(row_s), int'(col_s), MAX_SIZE) * DATA_WIDTH;
  end

  // Walk order: B may be streamed column-major; A is always row-major.
  always_comb begin
`ifdef LOADER_B_COLMAJOR_EN
    col_major_s = (state_r == LOAD_B);
`else
    col_major_s = 1'b0;
`endif
  end

  matrix_rc_counter #(
    .RC_W (RC_W),
    .N_W  (N_W)
  ) u_rc (
    .clk       (clk),
    .rst       (rst),
    .clear     (cfg_accept_s),
    .step      (elem_accept_s),
    .n         (matrix_size_r[N_W-1:0]),
    .col_major (col_major_s),
    .row       (row_s),
    .col       (col_s),
    .last      (last_s)
  );

  // Load sequencer: config, A fill, B fill, hold until the consumer captures.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      a_r           <= {FLAT_W{1'b0}};
      b_r           <= {FLAT_W{1'b0}};
      matrix_size_r <= 32'd0;
      mats_valid_r  <= 1'b0;
      cfg_err_r     <= 1'b0;
    end else begin
      cfg_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_legal_s) begin
              matrix_size_r <= cfg_size;
              a_r           <= {FLAT_W{1'b0}};
              b_r           <= {FLAT_W{1'b0}};
              state_r       <= LOAD_A;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end
        end
        LOAD_A: begin
          if (in_valid) begin
            a_r[wr_base_s +: DATA_WIDTH] <= in_data;
            if (last_s) begin
              state_r <= LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            b_r[wr_base_s +: DATA_WIDTH] <= in_data;
            if (last_s) begin
              state_r      <= HOLD;
              mats_valid_r <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (mats_valid_r && mats_ready) begin
            mats_valid_r <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          mats_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready   = cfg_ready_s;
  assign in_ready    = in_ready_s;
  assign cfg_err     = cfg_err_r;
  assign matrix_size = matrix_size_r;
  assign A           = a_r;
  assign B           = b_r;
  assign mats_valid  = mats_valid_r;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed self-checking bench for matrix_stream_loader (MAX_SIZE=10, DATA_WIDTH=32).
// With LOADER_B_COLMAJOR_EN defined, the N=2 job streams B as 5,7,6,8.
module tb_matrix_stream_loader;

  localparam int MS = 10;
  localparam int DW = 32;
  localparam int FW = MS * MS * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [31:0]   cfg_size = 32'd0;
  logic          cfg_ready;
  logic          cfg_err;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [31:0]   matrix_size;
  logic [FW-1:0] A;
  logic [FW-1:0] B;
  logic          mats_valid;
  logic          mats_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  matrix_stream_loader #(.MAX_SIZE(MS), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_size    (cfg_size),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .matrix_size (matrix_size),
    .A           (A),
    .B           (B),
    .mats_valid  (mats_valid),
    .mats_ready  (mats_ready)
  );

  always #5 clk = ~clk;

  // Count element handshakes at the active edge.
  always @(posedge clk) begin
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ea(input int r, input int c);
    return A[(r*MS+c)*DW +: DW];
  endfunction

  function automatic logic [31:0] eb(input int r, input int c);
    return B[(r*MS+c)*DW +: DW];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_cfg(input logic [31:0] n);
    chk("cfg_ready_before_cfg", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_size  = n;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    chk("push_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  logic [FW-1:0] a_snap;
  logic [FW-1:0] b_snap;
  int            acc0;
  int            bad;
  int            c00, c01, c10, c11;

  initial begin
    // Reset state
    do_reset();
    chk("rst_mats_valid", mats_valid, 0);
    chk("rst_matrix_size", matrix_size, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_A_zero", (A == '0), 1);

    // Illegal sizes 0 and 11
    send_cfg(32'd0);
    chk("err0_pulse", cfg_err, 1);
    chk("err0_cfg_ready", cfg_ready, 1);
    tick();
    chk("err0_pulse_end", cfg_err, 0);
    send_cfg(32'd11);
    chk("err11_pulse", cfg_err, 1);
    chk("err11_cfg_ready", cfg_ready, 1);
    chk("err_matrix_size", matrix_size, 0);
    tick();
    chk("err11_pulse_end", cfg_err, 0);

    // N=2 job
    send_cfg(32'd2);
    chk("n2_matrix_size", matrix_size, 2);
    chk("n2_cfg_ready_low", cfg_ready, 0);
    chk("n2_in_ready", in_ready, 1);
    push(32'd1); push(32'd2); push(32'd3); push(32'd4);
`ifdef LOADER_B_COLMAJOR_EN
    push(32'd5); push(32'd7); push(32'd6);
`else
    push(32'd5); push(32'd6); push(32'd7);
`endif
    chk("n2_not_valid_before_last", mats_valid, 0);
    push(32'd8);
    chk("n2_mats_valid", mats_valid, 1);
    chk("n2_A01", ea(0, 1), 2);
    chk("n2_B10", eb(1, 0), 7);
    chk("n2_B01", eb(0, 1), 6);
    chk("n2_A02_zero", ea(0, 2), 0);
    chk("n2_A20_zero", ea(2, 0), 0);
    c00 = ea(0,0)*eb(0,0) + ea(0,1)*eb(1,0);
    c01 = ea(0,0)*eb(0,1) + ea(0,1)*eb(1,1);
    c10 = ea(1,0)*eb(0,0) + ea(1,1)*eb(1,0);
    c11 = ea(1,0)*eb(0,1) + ea(1,1)*eb(1,1);
    chk("n2_C00", c00, 19);
    chk("n2_C01", c01, 22);
    chk("n2_C10", c10, 43);
    chk("n2_C11", c11, 50);
    mats_ready = 1'b1;
    tick();
    mats_ready = 1'b0;
    chk("n2_release_valid", mats_valid, 0);
    chk("n2_release_idle", cfg_ready, 1);

    // N=3 with gaps, long hold
    send_cfg(32'd3);
    chk("n3_A_cleared", (A == '0), 1);
    acc0 = acc_cnt;
    for (int i = 0; i < 18; i++) begin
      if (i % 4 == 1) begin
        tick();
        tick();
      end
      push((i < 9) ? (i + 1) : (101 + i - 9));
    end
    chk("n3_mats_valid", mats_valid, 1);
    chk("n3_A22", ea(2, 2), 9);
    chk("n3_B12", eb(1, 2), 106);
    chk("n3_A03_zero", ea(0, 3), 0);
    a_snap = A;
    b_snap = B;
    in_valid = 1'b1;
    in_data  = 32'hDEAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("n3_hold_valid", mats_valid, 1);
      chk("n3_hold_stable", (A === a_snap) && (B === b_snap), 1);
    end
    in_valid = 1'b0;
    chk("n3_accept_count", acc_cnt - acc0, 18);
    mats_ready = 1'b1;
    tick();
    mats_ready = 1'b0;
    chk("n3_idle_after_ready", cfg_ready, 1);

    // Reset during LOAD_B
    send_cfg(32'd2);
    push(32'd1); push(32'd2); push(32'd3); push(32'd4);
    push(32'd5); push(32'd6); push(32'd7);
    chk("rstmid_B_partial", eb(0, 0), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_A_zero", (A == '0), 1);
    chk("rstmid_B_zero", (B == '0), 1);
    chk("rstmid_mats_valid", mats_valid, 0);
    chk("rstmid_cfg_ready", cfg_ready, 1);
    chk("rstmid_matrix_size", matrix_size, 0);
    tick();
    chk("rstmid_still_idle", mats_valid, 0);

    // N=10 full size, one element per cycle
    send_cfg(32'd10);
    acc0 = acc_cnt;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      in_data = (k < 100) ? k : (1000 + k - 100);
      tick();
    end
    in_valid = 1'b0;
    chk("n10_accept_200_in_200", acc_cnt - acc0, 200);
    chk("n10_mats_valid", mats_valid, 1);
    chk("n10_A99", ea(9, 9), 99);
    chk("n10_A53", ea(5, 3), 53);
    chk("n10_B99", eb(9, 9), 1099);
    bad = 0;
    for (int r = 0; r < MS; r++) begin
      for (int c = 0; c < MS; c++) begin
        if (ea(r, c) !== 32'(r*MS + c)) bad++;
      end
    end
    chk("n10_all_A_slots", bad, 0);
    mats_ready = 1'b1;
    tick();
    mats_ready = 1'b0;
    chk("n10_release", cfg_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
